glyph_lane_renderer: RTL and testbench

Parametrised, sequential successor to the three-letter falling-glyph framebuffer composer. It draws CHANNELS bitmap glyphs, each in its own fixed vertical lane at a per-channel row offset, into a monochrome FB_W×FB_H framebuffer. Rendering is one framebuffer row per clock; the finished frame is committed atomically to the output register. The block sits between the game/lane logic, which supplies glyph bitmaps from the letter decoder plus row positions, and the display scan-out, which reads `framebuffer`.

---
 rtl/glyph_lane_renderer.sv | 140 ++++++++++++++
 tb/tb_glyph_lane_renderer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/glyph_lane_renderer.sv
// Sequential glyph-lane framebuffer composer: renders one row per clock into a
// work buffer from latched lane state, then commits the whole frame at once.

module glyph_lane_row #(
  parameter int FB_W      = 40,
  parameter int FB_H      = 30,
  parameter int GLYPH_W   = 6,
  parameter int GLYPH_H   = 5,
  parameter int XS        = 6,
  parameter int CLIP_MODE = 0,
  parameter int YW        = 5
) (
  input  logic                       en,
  input  logic [YW-1:0]              row,
  input  logic [YW-1:0]              ypos,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph,
  output logic [FB_W-1:0]            row_bits
);
  logic [YW:0]         g;
  logic                drawn, hit;
  logic [GLYPH_W-1:0]  gl_row;

  // One extra bit so rows above the glyph show up as negative, not wrapped.
  assign g     = {1'b0, row} - {1'b0, ypos};
  assign drawn = (CLIP_MODE != 0) || ({1'b0, ypos} <= (YW+1)'(FB_H - GLYPH_H));
  assign hit   = en && drawn && !g[YW] && (g < (YW+1)'(GLYPH_H));

  always_comb begin
    gl_row = '0;
    for (int i = 0; i < GLYPH_H; i++)
      if (g == (YW+1)'(i)) gl_row = glyph[(GLYPH_H-1-i)*GLYPH_W +: GLYPH_W];
  end

  always_comb begin
    row_bits = '0;
    if (hit) row_bits[FB_W-1-XS -: GLYPH_W] = gl_row;
  end
endmodule

module glyph_lane_renderer #(
  parameter int FB_W       = 40,
  parameter int FB_H       = 30,
  parameter int CHANNELS   = 3,
  parameter int GLYPH_W    = 6,
  parameter int GLYPH_H    = 5,
  parameter int X0         = 6,
  parameter int LANE_PITCH = 10,
  parameter int CLIP_MODE  = 0,
  parameter int YW         = $clog2(FB_H)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [CHANNELS-1:0]                 enable,
  input  logic [CHANNELS*GLYPH_W*GLYPH_H-1:0] glyphs,
  input  logic [CHANNELS*YW-1:0]              ypos,
  output logic                                busy,
  output logic                                done,
  output logic [FB_W*FB_H-1:0]                framebuffer
);
  localparam int GB = GLYPH_W * GLYPH_H;

  if (X0 + (CHANNELS-1)*LANE_PITCH + GLYPH_W > FB_W) begin : g_bad_geom
    $error("glyph_lane_renderer: lanes do not fit in FB_W");
  end

  typedef struct packed {
    logic [CHANNELS-1:0]         en;
    logic [CHANNELS-1:0][GB-1:0] glyph;
    logic [CHANNELS-1:0][YW-1:0] ypos;
  } req_t;

  typedef enum logic [1:0] {IDLE, RENDER, COMMIT} state_t;

  state_t                        state, state_nxt;
  req_t                          shadow;
  logic [YW-1:0]                 row_cnt;
  logic [FB_W*FB_H-1:0]          work;
  logic [CHANNELS-1:0][FB_W-1:0] lane_rows;
  logic [FB_W-1:0]               row_or;
  logic                          load, last;

  assign last = (row_cnt == YW'(FB_H - 1));

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RENDER;
      RENDER:  if (last)  state_nxt = COMMIT;
      COMMIT:             state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    load = (state == IDLE) && start;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    glyph_lane_row #(
      .FB_W(FB_W), .FB_H(FB_H), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H),
      .XS(X0 + c*LANE_PITCH), .CLIP_MODE(CLIP_MODE), .YW(YW)
    ) u_lane (
      .en(shadow.en[c]), .row(row_cnt), .ypos(shadow.ypos[c]),
      .glyph(shadow.glyph[c]), .row_bits(lane_rows[c])
    );
  end

  always_comb begin
    row_or = '0;
    for (int c = 0; c < CHANNELS; c++) row_or |= lane_rows[c];
  end

  // Every work row is rewritten each frame, so no clear pass is needed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      row_cnt     <= '0;
      work        <= '0;
      done        <= 1'b0;
      framebuffer <= '0;
    end else begin
      done <= (state == COMMIT);
      if (load) begin
        shadow  <= {enable, glyphs, ypos};
        row_cnt <= '0;
      end
      if (state == RENDER) begin
        work[row_cnt*FB_W +: FB_W] <= row_or;
        if (!last) row_cnt <= row_cnt + 1'b1;
      end
      if (state == COMMIT) framebuffer <= work;
    end
  end
endmodule

// File: tb/tb_glyph_lane_renderer.sv
// Bench for glyph_lane_renderer: hidden-clip and visible-clip instances share
// stimulus; expected frames are queued at start and checked at done.

module tb_glyph_lane_renderer;
  localparam int FB_W = 40, FB_H = 30, CH = 3, GW = 6, GH = 5;
  localparam int X0 = 6, P = 10, YW = 5, GB = GW*GH, FBB = FB_W*FB_H;

  logic              clock = 1'b0;
  logic              reset_n, start;
  logic [CH-1:0]     enable;
  logic [CH*GB-1:0]  glyphs;
  logic [CH*YW-1:0]  ypos;
  logic              busy0, done0, busy1, done1;
  logic [FBB-1:0]    fb0, fb1;

  typedef struct { logic [FBB-1:0] f0; logic [FBB-1:0] f1; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  glyph_lane_renderer #(.CLIP_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .enable(enable),
    .glyphs(glyphs), .ypos(ypos), .busy(busy0), .done(done0), .framebuffer(fb0));
  glyph_lane_renderer #(.CLIP_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .enable(enable),
    .glyphs(glyphs), .ypos(ypos), .busy(busy1), .done(done1), .framebuffer(fb1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FBB-1:0] model(input logic [CH-1:0] en, input logic [CH*GB-1:0] gl,
                                           input logic [CH*YW-1:0] yp, input bit clip);
    logic [FBB-1:0] fb = '0;
    for (int c = 0; c < CH; c++) begin
      int y = int'(yp[c*YW +: YW]);
      if (!en[c]) continue;
      if (!clip && y > FB_H - GH) continue;
      for (int g = 0; g < GH; g++) begin
        int r = y + g;
        if (r >= FB_H) continue;
        for (int j = 0; j < GW; j++) begin
          int x = X0 + c*P + j;
          fb[r*FB_W + FB_W-1-x] |= gl[c*GB + (GH-1-g)*GW + GW-1-j];
        end
      end
    end
    return fb;
  endfunction

  task automatic chk_frame(input string tag, input logic [FBB-1:0] obs, input logic [FBB-1:0] exp);
    for (int r = 0; r < FB_H; r++)
      chk($sformatf("%s row%0d", tag, r), 64'(obs[r*FB_W +: FB_W]), 64'(exp[r*FB_W +: FB_W]));
  endtask

  task automatic randomize_in();
    glyphs = CH*GB'({$urandom, $urandom, $urandom});
    ypos   = CH*YW'($urandom);
    enable = CH'($urandom);
  endtask

  // Drive start for one edge and queue the frame both instances must produce.
  task automatic kick();
    exp_t e;
    e.f0 = model(enable, glyphs, ypos, 1'b0);
    e.f1 = model(enable, glyphs, ypos, 1'b1);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen (or after the cycle budget).
  task automatic wait_frame(input string tag, input int mut_at, input int re_at);
    int cyc = 1, b0 = 0, b1 = 0, dc0 = 0, dc1 = 0;
    exp_t e;
    while (cyc <= 100 && dc0 == 0) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) dc0 = cyc;
      if (done1) dc1 = cyc;
      if (cyc == mut_at) randomize_in();
      start = (cyc == re_at);
      if (dc0 == 0) begin
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, " busy0 cycles"}, 64'(b0), 64'(FB_H+1));
    chk({tag, " busy1 cycles"}, 64'(b1), 64'(FB_H+1));
    chk({tag, " done0 cycle"}, 64'(dc0), 64'(FB_H+2));
    chk({tag, " done1 cycle"}, 64'(dc1), 64'(FB_H+2));
    if (dc0 != 0 && sb.size() != 0) begin
      e = sb.pop_front();
      chk_frame({tag, " fb0"}, fb0, e.f0);
      chk_frame({tag, " fb1"}, fb1, e.f1);
    end else begin
      chk({tag, " scoreboard entry"}, 64'(sb.size()), 64'd1);
      sb.delete();
    end
  endtask

  task automatic no_done(input string tag, input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clock);
      if (done0 || done1) cnt++;
    end
    chk({tag, " spurious done"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CH*GB-1:0] g_sav;
    reset_n = 1'b0; start = 1'b0; enable = '0; glyphs = '0; ypos = '0;
    repeat (3) @(negedge clock);
    chk("rst fb0 ones", 64'($countones(fb0)), 64'd0);
    chk("rst busy0", 64'(busy0), 64'd0);
    chk("rst done0", 64'(done0), 64'd0);
    reset_n = 1'b1;
    repeat (50) @(negedge clock);
    chk("idle fb0 ones", 64'($countones(fb0)), 64'd0);
    chk("idle fb1 ones", 64'($countones(fb1)), 64'd0);
    chk("idle busy", 64'({busy0, busy1}), 64'd0);
    chk("idle done", 64'({done0, done1}), 64'd0);

    // Lane 0, solid glyph at the top.
    enable = 3'b001; glyphs = '0; glyphs[GB-1:0] = '1; ypos = '0;
    kick(); wait_frame("t2", 0, 0);
    chk("t2 popcount", 64'($countones(fb0)), 64'd30);
    chk("t2 r0 bits", 64'(fb0[33:28]), 64'h3f);
    chk("t2 r4 bits", 64'(fb0[193:188]), 64'h3f);
    @(negedge clock);
    chk("t2 done width", 64'({done0, done1}), 64'd0);

    // Lane 2 at the last fully visible row, then one row lower.
    enable = 3'b100; glyphs = '0; glyphs[89:60] = 30'h2b5_9c3e; ypos = '0; ypos[14:10] = 5'd25;
    kick(); wait_frame("t3a", 0, 0);
    chk("t3a row25", 64'(fb0[1013:1008]), 64'(glyphs[89:84]));
    chk("t3a row29", 64'(fb0[1173:1168]), 64'(glyphs[65:60]));
    ypos[14:10] = 5'd26;
    kick(); wait_frame("t3b", 0, 0);
    chk("t3b fb0 blank", 64'($countones(fb0)), 64'd0);

    // Lane 1 partly and fully below the frame.
    enable = 3'b010; glyphs = '0; glyphs[59:30] = '1; ypos = '0; ypos[9:5] = 5'd28;
    kick(); wait_frame("t4a", 0, 0);
    chk("t4a fb1 r28", 64'(fb1[1143:1138]), 64'h3f);
    chk("t4a fb1 r29", 64'(fb1[1183:1178]), 64'h3f);
    chk("t4a fb1 ones", 64'($countones(fb1)), 64'd12);
    chk("t4a fb0 ones", 64'($countones(fb0)), 64'd0);
    ypos[9:5] = 5'd31;
    kick(); wait_frame("t4b", 0, 0);
    chk("t4b fb1 ones", 64'($countones(fb1)), 64'd0);
    chk("t4b fb1 rows01", fb1[79:16] | 64'(fb1[15:0]), 64'd0);

    // Random frames, each started in the previous done cycle.
    for (int i = 0; i < 5; i++) begin
      randomize_in();
      kick(); wait_frame($sformatf("rnd%0d", i), 0, 0);
    end

    // Input churn and a re-start while busy must not disturb the frame.
    enable = 3'b111; glyphs = CH*GB'({32'h1234_5678, 32'h9abc_def0, 32'h0f1e_2d3c}); ypos = {5'd3, 5'd12, 5'd24};
    g_sav = glyphs;
    kick(); wait_frame("t5", 5, 10);
    chk("t5 inputs moved", 64'(glyphs != g_sav), 64'd1);
    no_done("t5", 40);

    // Reset mid-render aborts the frame.
    kick();
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("t6 fb0 ones", 64'($countones(fb0)), 64'd0);
    chk("t6 fb1 ones", 64'($countones(fb1)), 64'd0);
    chk("t6 busy", 64'({busy0, busy1}), 64'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    no_done("t6", 40);
    randomize_in(); enable = 3'b111;
    kick(); wait_frame("t6 restart", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
